// File: rtl/rvvi_host_rx_pkg.sv
// rvvi_host_rx_pkg
//   Shared definitions for the RVVI-over-Ethernet link: core configuration
//   type, frame layout constants (beat indices, header length, default
//   EthType), receiver FSM state encoding and the header beat comparator.
package rvvi_host_rx_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT_CFG = '{XLEN: 64};

    // Frame layout, shared with the transmit packetizer.
    localparam int unsigned RVVI_HDR_BYTES       = 14;
    // Header plus the 2 pad bytes fills whole beats; this is the last one.
    localparam logic [3:0]  RVVI_HDR_LAST_BEAT   = 4'((RVVI_HDR_BYTES + 2) / 4 - 1);
    localparam logic [3:0]  RVVI_BEAT_FC_CMD     = 4'd4;
    localparam logic [3:0]  RVVI_BEAT_DELAY      = 4'd5;
    localparam logic [3:0]  RVVI_BEAT_MINSTR_LO  = 4'd6;
    localparam logic [3:0]  RVVI_BEAT_MINSTR_HI  = 4'd7;
    localparam logic [15:0] RVVI_DEFAULT_ETHTYPE = 16'h005c;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN
    } rx_state_t;

    // Header fields travel MSB first while frame byte k sits in lane k%4,
    // so each expected header word is the byte-reversed field slice.
    function automatic logic hdr_beat_ok(
        input logic [3:0]  beat,
        input logic [31:0] data,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] eth
    );
        logic ok;
        ok = 1'b1;
        case (beat)
            4'd0:    ok = (data == {dst[23:16], dst[31:24], dst[39:32], dst[47:40]});
            4'd1:    ok = (data == {src[39:32], src[47:40], dst[7:0], dst[15:8]});
            4'd2:    ok = (data == {src[7:0], src[15:8], src[23:16], src[31:24]});
            4'd3:    ok = (data[15:0] == {eth[7:0], eth[15:8]});
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rvvi_host_rx.sv
// rvvi_host_rx
//   Receives RVVI trace frames from an Ethernet MAC receive stream (no
//   backpressure), checks the Ethernet header against the expected
//   addresses/type, and on a well-formed frame publishes the decoded
//   instruction, inter-packet delay, frame count and command.
// Ports:
//   m_axi_aclk, m_axi_aresetn       clock, async active-low reset
//   RvviAxiRdata/Rstrb/Rlast/Rvalid receive stream beats (32-bit)
//   DstMac, SrcMac, EthType         expected header, quasi-static
//   Valid                           one-cycle pulse per good frame
//   Minstr, InterPacketDelay,
//   FrameCount, Cmd                 decoded payload, held between frames
//   DropPulse                       one-cycle pulse per dropped frame
//   GoodCount, DropCount            saturating frame counters
module rvvi_host_rx
    import rvvi_host_rx_pkg::*;
#(
    parameter cvw_t P                 = CVW_DEFAULT_CFG,
    parameter int   FRAME_COUNT_WIDTH = 16
) (
    input  logic                         m_axi_aclk,
    input  logic                         m_axi_aresetn,
    input  logic [31:0]                  RvviAxiRdata,
    input  logic [3:0]                   RvviAxiRstrb,
    input  logic                         RvviAxiRlast,
    input  logic                         RvviAxiRvalid,
    input  logic [47:0]                  DstMac,
    input  logic [47:0]                  SrcMac,
    input  logic [15:0]                  EthType,
    output logic                         Valid,
    output logic [P.XLEN-1:0]            Minstr,
    output logic [31:0]                  InterPacketDelay,
    output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
    output logic [7:0]                   Cmd,
    output logic                         DropPulse,
    output logic [15:0]                  GoodCount,
    output logic [15:0]                  DropCount
);

    rx_state_t   state, state_next;
    logic [3:0]  beat_cnt;
    logic        err;

    logic [15:0] sh_fc;
    logic [7:0]  sh_cmd;
    logic [31:0] sh_delay;
    logic [31:0] sh_minstr_lo;
    logic [31:0] sh_minstr_hi;

    logic [3:0]  beat_idx;
    logic        hdr_bad;
    logic        strb_bad;
    logic        early_last;
    logic        err_now;
    logic        frame_end;
    logic        frame_good;
    logic [31:0] minstr_hi_now;
    logic [63:0] minstr_full;

    // A beat seen in IDLE is always beat 0, whatever the frame it came from.
    assign beat_idx   = (state == IDLE) ? 4'd0 : beat_cnt;
    assign hdr_bad    = ((state == IDLE) || (state == HDR)) &&
                        !hdr_beat_ok(beat_idx, RvviAxiRdata, DstMac, SrcMac, EthType);
    assign strb_bad   = (state != DRAIN) && (RvviAxiRstrb != 4'hF);
    assign early_last = (state != DRAIN) && RvviAxiRlast && (beat_idx < RVVI_BEAT_MINSTR_HI);
    assign err_now    = err | hdr_bad | strb_bad | early_last;
    assign frame_end  = RvviAxiRvalid && RvviAxiRlast;
    assign frame_good = frame_end && !err_now;

    // A frame ending exactly on beat 7 publishes before the shadow update lands.
    assign minstr_hi_now = ((state == PAYLOAD) && (beat_idx == RVVI_BEAT_MINSTR_HI)) ?
                           RvviAxiRdata : sh_minstr_hi;
    assign minstr_full   = {minstr_hi_now, sh_minstr_lo};

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (RvviAxiRvalid) begin
            if (RvviAxiRlast) begin
                state_next = IDLE;
            end else if (err_now) begin
                state_next = DRAIN;
            end else begin
                case (state)
                    IDLE:    state_next = HDR;
                    HDR:     if (beat_idx == RVVI_HDR_LAST_BEAT) state_next = PAYLOAD;
                    PAYLOAD: if (beat_idx == RVVI_BEAT_MINSTR_HI) state_next = DRAIN;
                    DRAIN:   state_next = DRAIN;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            beat_cnt         <= '0;
            err              <= 1'b0;
            sh_fc            <= '0;
            sh_cmd           <= '0;
            sh_delay         <= '0;
            sh_minstr_lo     <= '0;
            sh_minstr_hi     <= '0;
            Valid            <= 1'b0;
            DropPulse        <= 1'b0;
            Minstr           <= '0;
            InterPacketDelay <= '0;
            FrameCount       <= '0;
            Cmd              <= '0;
            GoodCount        <= '0;
            DropCount        <= '0;
        end else begin
            Valid     <= 1'b0;
            DropPulse <= 1'b0;
            if (RvviAxiRvalid) begin
                if (RvviAxiRlast) begin
                    beat_cnt <= '0;
                    err      <= 1'b0;
                end else begin
                    beat_cnt <= (beat_idx == 4'hF) ? beat_idx : beat_idx + 4'd1;
                    err      <= err_now;
                end

                if (state == PAYLOAD) begin
                    case (beat_idx)
                        RVVI_BEAT_FC_CMD: begin
                            sh_fc  <= RvviAxiRdata[15:0];
                            sh_cmd <= RvviAxiRdata[23:16];
                        end
                        RVVI_BEAT_DELAY:     sh_delay     <= RvviAxiRdata;
                        RVVI_BEAT_MINSTR_LO: sh_minstr_lo <= RvviAxiRdata;
                        RVVI_BEAT_MINSTR_HI: sh_minstr_hi <= RvviAxiRdata;
                        default: ;
                    endcase
                end

                if (frame_good) begin
                    Valid            <= 1'b1;
                    Minstr           <= minstr_full[P.XLEN-1:0];
                    InterPacketDelay <= sh_delay;
                    FrameCount       <= FRAME_COUNT_WIDTH'(sh_fc);
                    Cmd              <= sh_cmd;
                    GoodCount        <= (GoodCount == 16'hFFFF) ? GoodCount : GoodCount + 16'd1;
                end else if (frame_end) begin
                    DropPulse <= 1'b1;
                    DropCount <= (DropCount == 16'hFFFF) ? DropCount : DropCount + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/rvvi_host_rx.md
RVVI_HOST_RX -- requirements
Module: rvvihostrx

Interface
REQ-001 SHALL have parameter P, type cvw_t, no default; the core configuration, where P.XLEN sets the Minstr width.
REQ-002 SHALL have parameter FRAME_COUNT_WIDTH, default 16; the FrameCount width.
REQ-003 SHALL have port m_axi_aclk, input, 1 bit; the single clock.
REQ-004 SHALL have port m_axi_aresetn, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have the receive stream inputs from the Ethernet MAC:
- RvviAxiRdata, input, 32 bits; RX data.
- RvviAxiRstrb, input, 4 bits; RX byte keep.
- RvviAxiRlast, input, 1 bit; last beat of frame.
- RvviAxiRvalid, input, 1 bit; beat valid. There is no ready: every valid beat is consumed.
REQ-006 SHALL have the expected-header inputs, quasi-static:
- DstMac, input, 48 bits; local MAC.
- SrcMac, input, 48 bits; host MAC.
- EthType, input, 16 bits.
REQ-007 SHALL have the decoded outputs:
- Valid, output, 1 bit; one-cycle good-frame pulse.
- Minstr, output, P.XLEN bits.
- InterPacketDelay, output, 32 bits.
- FrameCount, output, FRAME_COUNT_WIDTH bits.
- Cmd, output, 8 bits.
REQ-008 SHALL have the status outputs:
- DropPulse, output, 1 bit.
- GoodCount, output, 16 bits.
- DropCount, output, 16 bits.

Function
REQ-009 SHALL map frame byte k to RvviAxiRdata[8*(k%4)+7 : 8*(k%4)], so that beat n carries bytes 4n..4n+3.
REQ-010 SHALL use this frame layout, with header fields most-significant byte first:
- bytes 0-5: DstMac
- bytes 6-11: SrcMac
- bytes 12-13: EthType
- bytes 14-15: pad, ignored
REQ-011 SHALL take the payload beats as little-endian words:
- beat 4: [15:0] FrameCount, [23:16] Cmd
- beat 5: InterPacketDelay
- beat 6: Minstr[31:0]
- beat 7: Minstr[63:32]; ignored when P.XLEN=32
REQ-012 SHALL use FSM states IDLE, HDR, PAYLOAD and DRAIN, with reset state IDLE.
REQ-013 SHALL, in IDLE, treat a valid beat as beat 0: go to HDR, or to DRAIN on a beat-0 mismatch.
- If that beat has Rlast=1, drop the frame (runt) and stay in IDLE.
REQ-014 SHALL, in HDR, compare beats 1-3 and enter PAYLOAD after beat 3.
REQ-015 SHALL capture beats 4-7 in PAYLOAD into shadow registers and keep a 4-bit beat counter.
REQ-016 SHALL go from PAYLOAD to DRAIN after beat 7 when Rlast=0, where DRAIN discards beats until Rlast, then returns to IDLE.
REQ-017 SHALL drop a frame on any of:
- DstMac, SrcMac or EthType mismatch
- Rstrb not equal to 4'hF on beats 0-7
- Rlast on any beat before beat 7
REQ-018 SHALL keep the error flag sticky until frame end; a dropping frame SHALL enter DRAIN, unless Rlast is seen on the offending beat, in which case it returns to IDLE.
REQ-019 SHALL, on the Rlast beat of a good frame (beat ≥7), do the following in the next cycle:
- copy the shadows to Minstr, InterPacketDelay, FrameCount and Cmd
- assert Valid for 1 cycle
- increment GoodCount
REQ-020 SHALL, on the Rlast beat of a dropped frame, assert DropPulse for 1 cycle in the next cycle and increment DropCount; the decoded outputs SHALL be unchanged.
REQ-021 SHALL hold the decoded outputs between good frames.
REQ-022 SHALL saturate GoodCount and DropCount at 16'hFFFF with no wrap.
REQ-023 SHALL leave all state unchanged on cycles with RvviAxiRvalid=0, so gaps within a frame are legal.
REQ-024 SHALL never assert Valid and DropPulse in the same cycle.

Reset
REQ-025 SHALL, while m_axi_aresetn=0, asynchronously force:
- FSM to IDLE
- beat counter, shadows and all outputs to 0
REQ-026 SHALL release reset synchronously to m_axi_aclk.
REQ-027 SHALL treat the first valid beat after reset release as beat 0; a frame caught mid-stream SHALL be dropped by header mismatch, not reported as good.

Structure
REQ-028 SHALL take the beat indices (FrameCount/Cmd beat=4, delay=5, Minstr=6/7), the header byte length of 14 and the default EthType 16'h005c from the shared cvw package, shared with the transmit packetizer.
REQ-029 SHALL be a single module with no new sub-modules; registers SHALL use existing codebase flop primitives.

Verification
REQ-030 SHALL verify a good frame:
- stimulus: 15 beats, correct header, FrameCount=16'h0007, Cmd=8'h01, delay=32'd50, Minstr=64'h0000_0000_0000_1234
- response: Valid for 1 cycle after Rlast, outputs equal these values, GoodCount=1
REQ-031 SHALL verify DstMac mismatch: byte 0 corrupted -> DropPulse=1, DropCount=1, Valid=0, outputs unchanged from REQ-030.
REQ-032 SHALL verify a runt: Rlast on beat 5 -> DropPulse, FSM back in IDLE, and a following good frame accepted.
REQ-033 SHALL verify bad strobe: Rstrb=4'h7 on beat 6 -> frame dropped.
REQ-034 SHALL verify a gapped stream: Rvalid deasserted for 3 cycles between beats 2 and 3 -> frame still accepted with the same values.
REQ-035 SHALL verify mid-frame reset: m_axi_aresetn asserted after beat 5 and released with beats 6-14 still arriving -> no Valid, one DropPulse, GoodCount=0.
